// File: rtl/mips_instr_encoder.sv
// MIPS instruction encoder: converts symbolic instruction requests into 32-bit
// words with sequential word addresses for filling instruction memory.
// One registered output stage with valid/ready handshakes on both sides.
module mips_instr_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [3:0]        InOp,
    input  logic [5:0]        InFunc,
    input  logic [4:0]        InRs,
    input  logic [4:0]        InRt,
    input  logic [4:0]        InRd,
    input  logic [4:0]        InShamt,
    input  logic [15:0]       InImm,
    input  logic [25:0]       InTarget,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [31:0]       OutInstr,
    output logic [ADDR_W-1:0] OutAddr,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              Error
);

    localparam int unsigned CNT_W   = ADDR_W + 1;
    localparam int unsigned INSTR_W = 32;

    // Request op classes
    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_LW    = 4'd1;
    localparam logic [3:0] OP_SW    = 4'd2;
    localparam logic [3:0] OP_BEQ   = 4'd3;
    localparam logic [3:0] OP_J     = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_ADDI  = 4'd6;
    localparam logic [3:0] OP_ADDIU = 4'd7;
    localparam logic [3:0] OP_ANDI  = 4'd8;
    localparam logic [3:0] OP_LUI   = 4'd9;
    localparam logic [3:0] OP_SLTI  = 4'd10;
    localparam logic [3:0] OP_SLTIU = 4'd11;
    localparam logic [3:0] OP_XORI  = 4'd12;

    // MIPS primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // Shift functs that use the shamt field instead of rs
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_LOADED = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    next_addr_q, next_addr_d;
    logic                error_q, error_d;

    logic [INSTR_W-1:0]  enc_word;
    logic                enc_legal;
    logic [5:0]          i_opc;
    logic                is_shift;
    logic                accept;
    logic                load;
    logic                handoff;

    // Output ports come straight from registers; InReady is the only combinational one
    assign OutValid = (state_q == S_LOADED);
    assign OutInstr = instr_q;
    assign OutAddr  = addr_q;
    assign Count    = count_q;
    assign Full     = next_addr_q[ADDR_W];
    assign Error    = error_q;
    assign InReady  = (!OutValid || OutReady) && !Full;

    assign is_shift = (InFunc == FN_SLL) || (InFunc == FN_SRL) || (InFunc == FN_SRA);

    // Map the op class to an I-type primary opcode; illegal classes leave enc_legal low
    always_comb begin
        i_opc     = OPC_RTYPE;
        enc_legal = 1'b1;
        case (InOp)
            OP_RTYPE: i_opc = OPC_RTYPE;
            OP_J:     i_opc = OPC_J;
            OP_LW:    i_opc = OPC_LW;
            OP_SW:    i_opc = OPC_SW;
            OP_BEQ:   i_opc = OPC_BEQ;
            OP_ORI:   i_opc = OPC_ORI;
            OP_ADDI:  i_opc = OPC_ADDI;
            OP_ADDIU: i_opc = OPC_ADDIU;
            OP_ANDI:  i_opc = OPC_ANDI;
            OP_LUI:   i_opc = OPC_LUI;
            OP_SLTI:  i_opc = OPC_SLTI;
            OP_SLTIU: i_opc = OPC_SLTIU;
            OP_XORI:  i_opc = OPC_XORI;
            default:  enc_legal = 1'b0;
        endcase
    end

    // Assemble the instruction word; fields that the format does not use are forced to zero
    always_comb begin
        enc_word = '0;
        case (InOp)
            OP_RTYPE: begin
                if (is_shift) begin
                    enc_word = {OPC_RTYPE, 5'd0, InRt, InRd, InShamt, InFunc};
                end else begin
                    enc_word = {OPC_RTYPE, InRs, InRt, InRd, 5'd0, InFunc};
                end
            end
            OP_J:    enc_word = {OPC_J, InTarget};
            OP_LUI:  enc_word = {OPC_LUI, 5'd0, InRt, InImm};
            default: enc_word = {i_opc, InRs, InRt, InImm};
        endcase
    end

    // Handshake decode, next-state and next register values
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        count_d     = count_q;
        next_addr_d = next_addr_q;
        error_d     = error_q;

        handoff = (state_q == S_LOADED) && OutReady;
        accept  = InValid && InReady;
        load    = accept && enc_legal;

        if (handoff) begin
            count_d = count_q + CNT_W'(1);
        end

        // Illegal requests are consumed but only flag an error
        if (accept && !enc_legal) begin
            error_d = 1'b1;
        end

        if (load) begin
            instr_d     = enc_word;
            addr_d      = next_addr_q[ADDR_W-1:0];
            next_addr_d = next_addr_q + CNT_W'(1);
        end

        case (state_q)
            S_EMPTY: begin
                if (load) begin
                    state_d = S_LOADED;
                end
            end
            S_LOADED: begin
                if (handoff && !load) begin
                    state_d = next_addr_q[ADDR_W] ? S_DONE : S_EMPTY;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= S_EMPTY;
            instr_q     <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            next_addr_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            next_addr_q <= next_addr_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Testbench for mips_instr_encoder: directed scenarios plus randomized traffic,
// checked against a queue-based reference model on a wide and a small instance.
module tb_mips_instr_encoder;

    logic        CLK;
    logic        Reset;
    logic        InValid;
    logic [3:0]  InOp;
    logic [5:0]  InFunc;
    logic [4:0]  InRs;
    logic [4:0]  InRt;
    logic [4:0]  InRd;
    logic [4:0]  InShamt;
    logic [15:0] InImm;
    logic [25:0] InTarget;
    logic        OutReady;

    // Wide instance (ADDR_W=8)
    logic        b_ready, b_valid, b_full, b_error;
    logic [31:0] b_instr;
    logic [7:0]  b_addr;
    logic [8:0]  b_count;

    // Small instance (ADDR_W=2)
    logic        s_ready, s_valid, s_full, s_error;
    logic [31:0] s_instr;
    logic [1:0]  s_addr;
    logic [2:0]  s_count;

    mips_instr_encoder #(.ADDR_W(8)) dut_b (
        .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(b_ready),
        .InOp(InOp), .InFunc(InFunc), .InRs(InRs), .InRt(InRt), .InRd(InRd),
        .InShamt(InShamt), .InImm(InImm), .InTarget(InTarget),
        .OutValid(b_valid), .OutReady(OutReady), .OutInstr(b_instr),
        .OutAddr(b_addr), .Count(b_count), .Full(b_full), .Error(b_error)
    );

    mips_instr_encoder #(.ADDR_W(2)) dut_s (
        .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(s_ready),
        .InOp(InOp), .InFunc(InFunc), .InRs(InRs), .InRt(InRt), .InRd(InRd),
        .InShamt(InShamt), .InImm(InImm), .InTarget(InTarget),
        .OutValid(s_valid), .OutReady(OutReady), .OutInstr(s_instr),
        .OutAddr(s_addr), .Count(s_count), .Full(s_full), .Error(s_error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Which instance the model tracks: 0 wide, 1 small
    bit sel  = 1'b0;
    bit live = 1'b0;
    int cap  = 256;

    typedef struct {
        logic [31:0] instr;
        int          addr;
    } word_t;

    word_t q[$];
    int    m_next  = 0;
    int    m_count = 0;
    bit    m_err   = 1'b0;

    logic        o_ready, o_valid, o_full, o_error;
    logic [31:0] o_instr;
    logic [7:0]  o_addr;
    logic [8:0]  o_count;

    assign o_ready = sel ? s_ready : b_ready;
    assign o_valid = sel ? s_valid : b_valid;
    assign o_full  = sel ? s_full  : b_full;
    assign o_error = sel ? s_error : b_error;
    assign o_instr = sel ? s_instr : b_instr;
    assign o_addr  = sel ? {6'd0, s_addr}  : b_addr;
    assign o_count = sel ? {6'd0, s_count} : b_count;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoding built from field weights with plain arithmetic
    function automatic logic [31:0] ref_encode(input int op, input int func, input int rs,
                                               input int rt, input int rd, input int sh,
                                               input int imm, input int tgt);
        int opc_tab[13] = '{0, 'h23, 'h2B, 'h04, 'h02, 'h0D, 'h08, 'h09, 'h0C, 'h0F, 'h0A, 'h0B, 'h0E};
        longint unsigned w;
        int r;
        int s;
        r = rs;
        s = sh;
        if (op == 4) begin
            w = 2 * (longint'(1) << 26) + longint'(tgt);
        end else if (op == 0) begin
            if (func == 0 || func == 2 || func == 3) r = 0;
            else s = 0;
            w = longint'(r) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
                + longint'(s) * 64 + longint'(func);
        end else begin
            if (op == 9) r = 0;
            w = longint'(opc_tab[op]) * 67108864 + longint'(r) * 2097152
                + longint'(rt) * 65536 + longint'(imm);
        end
        return 32'(w);
    endfunction

    task automatic set_req(input int op, input int func, input int rs, input int rt,
                           input int rd, input int sh, input int imm, input int tgt);
        InOp     = 4'(op);
        InFunc   = 6'(func);
        InRs     = 5'(rs);
        InRt     = 5'(rt);
        InRd     = 5'(rd);
        InShamt  = 5'(sh);
        InImm    = 16'(imm);
        InTarget = 26'(tgt);
    endtask

    task automatic rand_req(input bit legal_only);
        int op;
        int fn;
        op = legal_only ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 15));
        fn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
        set_req(op, fn, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 65535)), int'($urandom_range(0, 67108863)));
    endtask

    // One clock cycle: predict handshake, advance model, compare after the edge
    task automatic tick();
        bit exp_ready;
        bit acc;
        bit hoff;
        logic [31:0] w;
        #1;
        exp_ready = (q.size() == 0 || OutReady) && (m_next < cap);
        if (!Reset && live) chk("in_ready", 64'(o_ready), 64'(exp_ready));
        acc  = !Reset && live && InValid && exp_ready;
        hoff = !Reset && live && (q.size() != 0) && OutReady;
        w    = ref_encode(int'(InOp), int'(InFunc), int'(InRs), int'(InRt), int'(InRd),
                          int'(InShamt), int'(InImm), int'(InTarget));
        @(posedge CLK);
        #1;
        if (Reset) begin
            q.delete();
            m_next  = 0;
            m_count = 0;
            m_err   = 1'b0;
            live    = 1'b1;
            chk("rst_instr", 64'(o_instr), 64'd0);
            chk("rst_addr", 64'(o_addr), 64'd0);
        end else begin
            if (hoff) begin
                void'(q.pop_front());
                m_count++;
            end
            if (acc) begin
                if (int'(InOp) < 13) begin
                    q.push_back('{instr: w, addr: m_next});
                    m_next++;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        chk("out_valid", 64'(o_valid), 64'(q.size() != 0));
        chk("count", 64'(o_count), 64'(m_count));
        chk("full", 64'(o_full), 64'(m_next == cap));
        chk("error", 64'(o_error), 64'(m_err));
        if (q.size() != 0) begin
            chk("out_instr", 64'(o_instr), 64'(q[0].instr));
            chk("out_addr", 64'(o_addr), 64'(q[0].addr));
        end
        @(negedge CLK);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);

        // Reset for two cycles, then idle: ready with nothing pending
        do_reset();
        chk("t1_valid", 64'(b_valid), 64'd0);
        chk("t1_count", 64'(b_count), 64'd0);
        tick();
        chk("t1_ready", 64'(b_ready), 64'd1);

        // Directed encodings streamed back-to-back
        OutReady = 1'b1;
        InValid  = 1'b1;
        set_req(6, 0, 1, 2, 0, 0, 'hFFFF, 0);
        tick();
        chk("t2_addi", 64'(b_instr), 64'h2022FFFF);
        chk("t2_addi_addr", 64'(b_addr), 64'd0);
        set_req(0, 'h20, 3, 4, 5, 0, 0, 0);
        tick();
        chk("t2_add", 64'(b_instr), 64'h00642820);
        chk("t2_add_addr", 64'(b_addr), 64'd1);
        set_req(0, 'h00, 7, 2, 3, 4, 0, 0);
        tick();
        chk("t2_sll", 64'(b_instr), 64'h00021900);
        chk("t2_sll_addr", 64'(b_addr), 64'd2);
        set_req(4, 0, 0, 0, 0, 0, 0, 'h100);
        tick();
        chk("t2_j", 64'(b_instr), 64'h08000100);
        set_req(9, 0, 9, 1, 0, 0, 'h1234, 0);
        tick();
        chk("t2_lui", 64'(b_instr), 64'h3C011234);
        InValid = 1'b0;
        tick();

        // Backpressure: output held while OutReady low, then resumes at full rate
        InValid = 1'b1;
        set_req(5, 0, 4, 6, 0, 0, 'h00F0, 0);
        tick();
        OutReady = 1'b0;
        set_req(12, 0, 8, 9, 0, 0, 'hAAAA, 0);
        tick();
        tick();
        tick();
        chk("t3_held_addr", 64'(b_addr), 64'd5);
        OutReady = 1'b1;
        tick();
        chk("t3_next_addr", 64'(b_addr), 64'd6);
        chk("t3_count", 64'(b_count), 64'd6);
        InValid = 1'b0;
        tick();

        // Illegal op between two legal ones
        do_reset();
        InValid = 1'b1;
        set_req(5, 0, 1, 1, 0, 0, 'h0001, 0);
        tick();
        set_req(13, 0, 1, 1, 1, 1, 1, 1);
        tick();
        chk("t4_error", 64'(b_error), 64'd1);
        set_req(12, 0, 2, 2, 0, 0, 'h0002, 0);
        tick();
        chk("t4_addr", 64'(b_addr), 64'd1);
        InValid = 1'b0;
        tick();

        // Small instance: fill all four addresses, fifth request held off
        sel = 1'b1;
        cap = 4;
        do_reset();
        OutReady = 1'b1;
        InValid  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (int'(s_ready) == 1 || i == 0) rand_req(1'b1);
            tick();
        end
        chk("t5_full", 64'(s_full), 64'd1);
        chk("t5_count", 64'(s_count), 64'd4);
        chk("t5_ready", 64'(s_ready), 64'd0);
        InValid = 1'b0;
        tick();

        // Reset while a word is stalled at the output
        sel = 1'b0;
        cap = 256;
        do_reset();
        OutReady = 1'b0;
        InValid  = 1'b1;
        set_req(1, 0, 3, 3, 0, 0, 'h0010, 0);
        tick();
        set_req(2, 0, 3, 4, 0, 0, 'h0020, 0);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t6_valid", 64'(b_valid), 64'd0);
        OutReady = 1'b1;
        tick();
        chk("t6_addr", 64'(b_addr), 64'd0);
        InValid = 1'b0;
        tick();

        // Randomized traffic on both instances
        for (int pass = 0; pass < 2; pass++) begin
            sel = (pass == 0);
            cap = (pass == 0) ? 4 : 256;
            do_reset();
            for (int i = 0; i < 300; i++) begin
                InValid  = ($urandom_range(0, 3) != 0);
                OutReady = ($urandom_range(0, 3) != 0);
                rand_req(($urandom_range(0, 7) != 0));
                Reset = ($urandom_range(0, 59) == 0);
                tick();
                Reset = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
